// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader
//  Description : Stream-to-RAM table loader. Packs MEM_COUNT consecutive
//                MEM_WIDTH-bit stream words into one line and writes all
//                2^MEM_DEPTH lines of a banked RAM, lane 0 first.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_loader #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 10,
  parameter int MEM_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 s_valid,
  input  logic [MEM_WIDTH-1:0] s_data,
  output logic                 s_ready,
  output logic                 wen,
  output logic [MEM_DEPTH-1:0] waddr,
  output logic [MEM_WIDTH-1:0] din [0:MEM_COUNT-1],
  output logic                 busy,
  output logic                 done
);

  // A single-lane configuration still needs a 1-bit lane counter.
  localparam int c_LANE_W = (MEM_COUNT > 1) ? $clog2(MEM_COUNT) : 1;
  localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(MEM_COUNT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [c_LANE_W-1:0]  r_lane_cnt;
  logic [MEM_DEPTH-1:0] r_line_cnt;
  logic [MEM_WIDTH-1:0] r_buf [0:MEM_COUNT-1];

  logic w_load;
  logic w_take;
  logic w_line_done;
  logic w_final;

  // An abort in the same cycle as a handshake drops that word.
  assign w_load      = (r_state == S_LOAD);
  assign w_take      = w_load && s_valid && !abort;
  assign w_line_done = w_take && (r_lane_cnt == c_LAST_LANE);
  assign w_final     = w_line_done && (r_line_cnt == {MEM_DEPTH{1'b1}});

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only honoured in IDLE, where it beats abort.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_final) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded straight from the state.
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Lane/line counters and the lane buffer for the line being assembled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane_cnt <= '0;
      r_line_cnt <= '0;
      for (int j = 0; j < MEM_COUNT; j++) begin
        r_buf[j] <= '0;
      end
    end else if ((r_state == S_IDLE) && start) begin
      r_lane_cnt <= '0;
      r_line_cnt <= '0;
      for (int j = 0; j < MEM_COUNT; j++) begin
        r_buf[j] <= '0;
      end
    end else if (w_load && abort) begin
      // Discard the partial line; the next start re-clears anyway.
      r_lane_cnt <= '0;
      r_line_cnt <= '0;
    end else if (w_take) begin
      for (int j = 0; j < MEM_COUNT; j++) begin
        if (r_lane_cnt == c_LANE_W'(j)) begin
          r_buf[j] <= s_data;
        end
      end
      if (w_line_done) begin
        r_lane_cnt <= '0;
        r_line_cnt <= r_line_cnt + MEM_DEPTH'(1);
      end else begin
        r_lane_cnt <= r_lane_cnt + c_LANE_W'(1);
      end
    end
  end

  // RAM write port: single-cycle pulse one cycle after a line completes.
  // The completing word bypasses the buffer straight into the top lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen   <= 1'b0;
      waddr <= '0;
      for (int j = 0; j < MEM_COUNT; j++) begin
        din[j] <= '0;
      end
    end else begin
      wen <= w_line_done;
      if (w_line_done) begin
        waddr <= r_line_cnt;
        for (int j = 0; j < MEM_COUNT; j++) begin
          din[j] <= (j == MEM_COUNT - 1) ? s_data : r_buf[j];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_loader
//  Description : Directed self-checking bench for rom_loader. Instance A uses
//                8-bit words, 4 lines, 2 lanes; instance B uses 1 lane.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

  logic clk;
  logic rst;

  // Instance A: MEM_WIDTH=8, MEM_DEPTH=2, MEM_COUNT=2
  logic       a_start, a_abort, a_valid, a_ready, a_wen, a_busy, a_done;
  logic [7:0] a_data;
  logic [1:0] a_waddr;
  logic [7:0] a_din [0:1];

  // Instance B: MEM_WIDTH=8, MEM_DEPTH=2, MEM_COUNT=1
  logic       b_start, b_abort, b_valid, b_ready, b_wen, b_busy, b_done;
  logic [7:0] b_data;
  logic [1:0] b_waddr;
  logic [7:0] b_din [0:0];

  int n_checks = 0;
  int n_errors = 0;

  rom_loader #(.MEM_WIDTH(8), .MEM_DEPTH(2), .MEM_COUNT(2)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .s_valid(a_valid), .s_data(a_data), .s_ready(a_ready),
    .wen(a_wen), .waddr(a_waddr), .din(a_din), .busy(a_busy), .done(a_done)
  );

  rom_loader #(.MEM_WIDTH(8), .MEM_DEPTH(2), .MEM_COUNT(1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .s_valid(b_valid), .s_data(b_data), .s_ready(b_ready),
    .wen(b_wen), .waddr(b_waddr), .din(b_din), .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output check for instance A.
  task automatic expect_a(input string tag, input bit ew, input int addr,
                          input int l0, input int l1, input bit ed, input bit er);
    check({tag, " wen"}, 32'(a_wen), 32'(ew));
    if (ew) begin
      check({tag, " waddr"}, 32'(a_waddr), 32'(addr));
      check({tag, " din0"}, 32'(a_din[0]), 32'(l0 & 8'hFF));
      check({tag, " din1"}, 32'(a_din[1]), 32'(l1 & 8'hFF));
    end
    check({tag, " done"}, 32'(a_done), 32'(ed));
    check({tag, " s_ready"}, 32'(a_ready), 32'(er));
    check({tag, " busy"}, 32'(a_busy), 32'(er));
  endtask

  // Full 8-word load on instance A. toggle: s_valid alternates 1/0.
  // restart: pulse start during LOAD and during DONE (must be ignored).
  task automatic run_a(input string tag, input int base, input bit toggle, input bit restart);
    int w;
    int cyc;
    bit v;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_abort = 1'b0;
    expect_a({tag, " started"}, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    w   = 0;
    cyc = 0;
    while (w < 8) begin
      v       = toggle ? (cyc % 2 == 0) : 1'b1;
      a_valid = v;
      a_data  = v ? 8'(base + w) : 8'hEE;
      a_start = restart && (cyc == 3);
      tick();
      a_start = 1'b0;
      if (v) begin
        expect_a($sformatf("%s w%0d", tag, w), (w % 2 == 1), w / 2,
                 base + w - 1, base + w, (w == 7), (w != 7));
        w++;
      end else begin
        expect_a($sformatf("%s gap%0d", tag, cyc), 1'b0, 0, 0, 0, 1'b0, 1'b1);
      end
      cyc++;
    end
    a_valid = 1'b0;
    a_start = restart;
    tick();
    a_start = 1'b0;
    expect_a({tag, " after done"}, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    expect_a({tag, " idle"}, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    a_start = 0; a_abort = 0; a_valid = 0; a_data = 0;
    b_start = 0; b_abort = 0; b_valid = 0; b_data = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Reset state
    expect_a("reset", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("reset waddr", 32'(a_waddr), 32'd0);
    check("reset din0", 32'(a_din[0]), 32'd0);
    check("reset din1", 32'(a_din[1]), 32'd0);
    check("reset b wen", 32'(b_wen), 32'd0);

    // Back-to-back full load
    run_a("full", 8'h01, 1'b0, 1'b0);

    // Bubbly stream plus ignored start pulses in LOAD and DONE
    run_a("toggle", 8'h01, 1'b1, 1'b1);

    // Abort after 3 words: one write, no done, 4th word dropped
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1;
      a_data  = 8'(i + 1);
      tick();
      expect_a($sformatf("abort w%0d", i), (i == 1), 0, 1, 2, 1'b0, 1'b1);
    end
    a_abort = 1'b1;
    a_data  = 8'h04;
    tick();
    a_abort = 1'b0;
    a_valid = 1'b0;
    expect_a("abort cycle", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    a_abort = 1'b1;                    // abort in IDLE: no effect
    tick();
    a_abort = 1'b0;
    expect_a("abort idle", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    a_abort = 1'b1;                    // start and abort together: start wins
    run_a("reload", 8'h11, 1'b0, 1'b0);

    // Asynchronous reset mid-load, right while a write is being presented
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_valid = 1'b1;
    a_data  = 8'h31;
    tick();
    a_data  = 8'h32;
    tick();
    expect_a("prerst", 1'b1, 0, 8'h31, 8'h32, 1'b0, 1'b1);
    a_data = 8'h33;
    #2;
    rst = 1'b1;
    #1;
    expect_a("rst async", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("rst waddr", 32'(a_waddr), 32'd0);
    check("rst din0", 32'(a_din[0]), 32'd0);
    check("rst din1", 32'(a_din[1]), 32'd0);
    tick();
    tick();
    expect_a("in rst", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    #2;
    rst     = 1'b0;
    a_valid = 1'b0;
    tick();
    expect_a("post rst", 1'b0, 0, 0, 0, 1'b0, 1'b0);
    run_a("after rst", 8'h41, 1'b0, 1'b0);

    // Single-lane instance: every word is a line
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("b started", 32'(b_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1;
      b_data  = 8'(8'hA0 + i);
      tick();
      check($sformatf("b w%0d wen", i), 32'(b_wen), 32'd1);
      check($sformatf("b w%0d waddr", i), 32'(b_waddr), 32'(i));
      check($sformatf("b w%0d din0", i), 32'(b_din[0]), 32'(8'hA0 + i));
      check($sformatf("b w%0d done", i), 32'(b_done), 32'(i == 3));
      check($sformatf("b w%0d s_ready", i), 32'(b_ready), 32'(i != 3));
    end
    b_valid = 1'b0;
    tick();
    check("b end wen", 32'(b_wen), 32'd0);
    check("b end busy", 32'(b_busy), 32'd0);
    check("b end done", 32'(b_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
